// File: rtl/ika2151_acc_sched_if.sv
// ika2151_acc_sched_if: control inputs and slot/strobe outputs of the accumulator sequencer
interface ika2151_acc_sched_if;
  logic       phi1_ncen_n;
  logic       cycle_sync;
  logic       wr;
  logic [2:0] wr_ch;
  logic [1:0] wr_rl;
  logic [2:0] wr_connect;
  logic       ne_wr;
  logic       ne_data;
  logic       cycle_12;
  logic       cycle_29;
  logic       cycle_00_16;
  logic       cycle_06_22;
  logic       cycle_01_to_16;
  logic       acc_sndadd;
  logic [1:0] rl;
  logic       ne;
  logic [4:0] slot;
  modport master (
    output phi1_ncen_n, cycle_sync, wr, wr_ch, wr_rl, wr_connect, ne_wr, ne_data,
    input  cycle_12, cycle_29, cycle_00_16, cycle_06_22, cycle_01_to_16, acc_sndadd, rl, ne, slot
  );
  modport slave (
    input  phi1_ncen_n, cycle_sync, wr, wr_ch, wr_rl, wr_connect, ne_wr, ne_data,
    output cycle_12, cycle_29, cycle_00_16, cycle_06_22, cycle_01_to_16, acc_sndadd, rl, ne, slot
  );
endinterface

// File: rtl/ika2151_acc_sched.sv
// ika2151_acc_sched: 32-slot sequencer, timing strobes and double-buffered channel config for the R/L accumulator
module ika2151_acc_sched #(
  parameter int ADD_DLY = 13
) (
  input logic emuclk,
  input logic mrst,
  ika2151_acc_sched_if.slave bus
);
  logic [4:0] cnt, nxt, ds;
  logic [7:0][1:0] rl_sh, rl_act;
  logic [7:0][2:0] con_sh, con_act;
  logic [7:0] pend, wr_hot;
  logic ne_sh, ne_act, ne_pend, commit;
  logic [2:0] con;
  logic [3:0] mask;
  always_comb begin
    nxt = bus.cycle_sync ? 5'd0 : cnt + 5'd1;
    ds = nxt - 5'(ADD_DLY);
    con = con_act[ds[2:0]];
    mask = con == 3'd7 ? 4'b1111 : con >= 3'd5 ? 4'b1110 : con == 3'd4 ? 4'b1100 : 4'b1000;
    commit = ds == 5'd31;
    wr_hot = bus.wr ? 8'd1 << bus.wr_ch : 8'd0;
  end
  // outputs use the pre-commit active config; new config shows from the next slot 0
  always_ff @(posedge emuclk) begin
    if (mrst) begin
      cnt <= 5'd31;
      rl_sh <= '0;
      rl_act <= '0;
      con_sh <= '0;
      con_act <= '0;
      pend <= '0;
      ne_sh <= 1'b0;
      ne_act <= 1'b0;
      ne_pend <= 1'b0;
      bus.cycle_12 <= 1'b0;
      bus.cycle_29 <= 1'b0;
      bus.cycle_00_16 <= 1'b0;
      bus.cycle_06_22 <= 1'b0;
      bus.cycle_01_to_16 <= 1'b0;
      bus.acc_sndadd <= 1'b0;
      bus.rl <= 2'b00;
      bus.ne <= 1'b0;
      bus.slot <= 5'd0;
    end else if (!bus.phi1_ncen_n) begin
      cnt <= nxt;
      bus.cycle_12 <= nxt == 5'd12;
      bus.cycle_29 <= nxt == 5'd29;
      bus.cycle_00_16 <= nxt[3:0] == 4'd0;
      bus.cycle_06_22 <= nxt[3:0] == 4'd6;
      bus.cycle_01_to_16 <= nxt >= 5'd1 && nxt <= 5'd16;
      bus.acc_sndadd <= mask[ds[4:3]];
      bus.rl <= rl_act[ds[2:0]];
      bus.ne <= ne_act;
      bus.slot <= ds;
      if (bus.wr) begin
        rl_sh[bus.wr_ch] <= bus.wr_rl;
        con_sh[bus.wr_ch] <= bus.wr_connect;
      end
      if (bus.ne_wr) ne_sh <= bus.ne_data;
      pend <= (commit ? 8'd0 : pend) | wr_hot;
      ne_pend <= (ne_pend & ~commit) | bus.ne_wr;
      if (commit && ne_pend) ne_act <= ne_sh;
      for (int i = 0; i < 8; i++)
        if (commit && pend[i]) begin
          rl_act[i] <= rl_sh[i];
          con_act[i] <= con_sh[i];
        end
    end
  end
endmodule
